// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder using one full-adder cell plus a carry flop.
// Ports: clk/rst (async active-high); start/a/b/cin request, captured while ready;
//        ready/busy/done status; sum/cout registered result, updated only on DONE entry.
// Latency: WIDTH RUN cycles after the accepted start edge, then one DONE cycle.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             c;
  logic [CW-1:0]    cnt;

  logic             s;
  logic             c_nxt;
  logic             last;
  logic             accept;

  // The single full-adder cell operating on the current LSBs.
  always_comb begin
    s      = a_sr[0] ^ b_sr[0] ^ c;
    c_nxt  = (a_sr[0] & b_sr[0]) | (a_sr[0] & c) | (b_sr[0] & c);
    last   = (cnt == LAST);
    accept = (state == IDLE) && start;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign ready = (state == IDLE);
  assign busy  = (state == RUN);
  assign done  = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      c      <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
    end else if (accept) begin
      a_sr <= a;
      b_sr <= b;
      c    <= cin;
      cnt  <= '0;
    end else if (state == RUN) begin
      a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
      b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
      // Sum bits enter at the MSB, so after WIDTH steps bit 0 lands at index 0.
      res_sr <= {s, res_sr[WIDTH-1:1]};
      c      <= c_nxt;
      cnt    <= cnt + CW'(1);
      if (last) begin
        // Publish the result including the bit being computed this edge.
        sum  <= {s, res_sr[WIDTH-1:1]};
        cout <= c_nxt;
      end
    end
  end

endmodule
